// File: rtl/muldiv_pkg.sv
// Shared types and opcode helpers for the RV32M multiply/divide execute unit.
package muldiv_pkg;

  // funct3 encodings of the M-extension operations
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } muldiv_state_e;

  function automatic logic is_signed_a(input muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(input muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_div(input muldiv_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem(input muldiv_op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and emit the quotient bit.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic            shift_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0] partial;

  // trial subtraction; the remainder stays below the divisor, so it fits XLEN bits
  always_comb begin
    partial = {rem_in, shift_in};
    q_bit   = (partial >= {1'b0, divisor});
    rem_out = q_bit ? XLEN'(partial - {1'b0, divisor}) : partial[XLEN-1:0];
  end

endmodule

// File: rtl/execute_muldiv.sv
// Multi-cycle RV32M MUL/DIV/REM execute unit: one bit per cycle shift-add
// multiply and restoring divide on magnitudes, with a one-cycle path for
// divide-by-zero, signed overflow and zero multiplicands.
// Optional: define EXECUTE_MULDIV_FAST_MUL_EN for a combinational multiplier
// (all multiplies take the one-cycle path; divide unchanged).
module execute_muldiv
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ValidE,
  input  logic [2:0]       MulDivOpE,
  input  logic [XLEN-1:0]  SrcAE,
  input  logic [XLEN-1:0]  SrcBE,
  input  logic [TAG_W-1:0] RdE,
  input  logic             FlushE,
  output logic             ReadyE,
  output logic             BusyE,
  output logic             ResultValidM,
  input  logic             ResultReadyM,
  output logic [XLEN-1:0]  ResultM,
  output logic [TAG_W-1:0] RdM
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e     state;
  muldiv_op_e        op_q;
  logic [XLEN-1:0]   opnd_q;      // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] prod_q;      // product, or {remainder, dividend/quotient}
  logic              neg_res_q;
  logic              neg_rem_q;
  logic [CNT_W-1:0]  count_q;
  logic              vld_q;
  logic [XLEN-1:0]   result_q;
  logic [TAG_W-1:0]  rd_q;

  muldiv_op_e        op_in;
  logic              sign_a, sign_b;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              special;
  logic [XLEN-1:0]   special_res;
  logic              accept;

  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   div_rem;
  logic              div_q;
  logic [2*XLEN-1:0] prod_step;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_raw, rem_raw;
  logic [XLEN-1:0]   calc_res;

  assign op_in  = muldiv_op_e'(MulDivOpE);
  assign sign_a = is_signed_a(op_in) & SrcAE[XLEN-1];
  assign sign_b = is_signed_b(op_in) & SrcBE[XLEN-1];
  assign a_mag  = sign_a ? -SrcAE : SrcAE;
  assign b_mag  = sign_b ? -SrcBE : SrcBE;

`ifdef EXECUTE_MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_p;
  assign fast_a = {{XLEN{sign_a}}, SrcAE};
  assign fast_b = {{XLEN{sign_b}}, SrcBE};
  assign fast_p = fast_a * fast_b;
`endif

  // detect operations whose result is known at accept time
  always_comb begin
    special     = 1'b0;
    special_res = '0;
    if (is_div(op_in)) begin
      if (SrcBE == '0) begin
        special     = 1'b1;
        special_res = is_rem(op_in) ? SrcAE : '1;
      end else if (is_signed_a(op_in) && (SrcAE == MIN_INT) && (SrcBE == '1)) begin
        special     = 1'b1;
        special_res = is_rem(op_in) ? '0 : MIN_INT;
      end
    end else begin
`ifdef EXECUTE_MULDIV_FAST_MUL_EN
      special     = 1'b1;
      special_res = (op_in == OP_MUL) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
`else
      special     = (SrcAE == '0) || (SrcBE == '0);
`endif
    end
  end

  div_step #(.XLEN(XLEN)) u_div_step (
    .rem_in   (prod_q[2*XLEN-1:XLEN]),
    .shift_in (prod_q[XLEN-1]),
    .divisor  (opnd_q),
    .rem_out  (div_rem),
    .q_bit    (div_q)
  );

  // next iteration of the product/remainder register
  always_comb begin
    mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    if (is_div(op_q)) prod_step = {div_rem, prod_q[XLEN-2:0], div_q};
    else              prod_step = {mul_sum, prod_q[XLEN-1:1]};
  end

  // sign fix applied to the value produced by the final iteration
  always_comb begin
    prod_fix = neg_res_q ? -prod_step : prod_step;
    quo_raw  = prod_step[XLEN-1:0];
    rem_raw  = prod_step[2*XLEN-1:XLEN];
    if (is_div(op_q)) begin
      if (is_rem(op_q)) calc_res = neg_rem_q ? -rem_raw : rem_raw;
      else              calc_res = neg_res_q ? -quo_raw : quo_raw;
    end else if (op_q == OP_MUL) begin
      calc_res = prod_fix[XLEN-1:0];
    end else begin
      calc_res = prod_fix[2*XLEN-1:XLEN];
    end
  end

  // ResultValidM is registered one cycle behind entry to DONE, so a new
  // request may only replace a result that has actually been presented
  assign ReadyE       = (state == ST_IDLE) || ((state == ST_DONE) && vld_q && ResultReadyM);
  assign accept       = ValidE && ReadyE && !FlushE;
  assign BusyE        = (state != ST_IDLE);
  assign ResultValidM = vld_q;
  assign ResultM      = result_q;
  assign RdM          = rd_q;

  // control FSM with operand capture, iteration and result hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= OP_MUL;
      opnd_q    <= '0;
      prod_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      count_q   <= '0;
      vld_q     <= 1'b0;
      result_q  <= '0;
      rd_q      <= '0;
    end else if (FlushE) begin
      state <= ST_IDLE;
      vld_q <= 1'b0;
    end else if (accept) begin
      op_q      <= op_in;
      rd_q      <= RdE;
      count_q   <= '0;
      vld_q     <= 1'b0;
      neg_res_q <= sign_a ^ sign_b;
      neg_rem_q <= sign_a;
      opnd_q    <= is_div(op_in) ? b_mag : a_mag;
      prod_q    <= {{XLEN{1'b0}}, (is_div(op_in) ? a_mag : b_mag)};
      if (special) begin
        result_q <= special_res;
        state    <= ST_DONE;
      end else begin
        state <= ST_CALC;
      end
    end else begin
      case (state)
        ST_CALC: begin
          prod_q  <= prod_step;
          count_q <= count_q + CNT_W'(1);
          if (count_q == CNT_LAST) begin
            result_q <= calc_res;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (vld_q && ResultReadyM) begin
            vld_q <= 1'b0;
            state <= ST_IDLE;
          end else begin
            vld_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/execute_muldiv.md
Name: execute_muldiv

Overview:
Parametrised multi-cycle execute unit for the RV32M MUL/DIV/REM family, generalising the single-cycle execute stage. It sits beside the ALU in the execute stage of each issue lane. It accepts one operation per valid/ready handshake and iterates one bit per cycle, with a special-case fast path. Results are returned through a valid/ready handshake to the memory stage. The hazard unit stalls the lane using BusyE.

Parameters:
XLEN, 32, operand/result width; must be a power of two, at least 8
TAG_W, 5, destination register tag width
CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ValidE  in  1  request valid
MulDivOpE  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
SrcAE  in  XLEN  rs1 operand (forwarded)
SrcBE  in  XLEN  rs2 operand (forwarded)
RdE  in  TAG_W  destination tag
FlushE  in  1  kill in-flight/pending operation (branch mispredict)
ReadyE  out  1  unit can accept a request this cycle
BusyE  out  1  operation in CALC or DONE (stall request)
ResultValidM  out  1  result available
ResultReadyM  in  1  consumer accepts result
ResultM  out  XLEN  result
RdM  out  TAG_W  tag of result

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state IDLE; ReadyE=1; BusyE=0; ResultValidM=0; ResultM=0; RdM=0; all internal registers 0.
- States:
  - IDLE: ReadyE=1. On accept (ValidE&ReadyE&!FlushE), latch operands, op and tag. Go to DONE if the op is a special case, else to CALC with count=0.
  - CALC: one iteration per cycle. Multiply uses shift-add on magnitudes into a 2*XLEN product register. Divide uses restoring division on magnitudes. After XLEN iterations (count==XLEN-1 at the edge), apply sign fix and go to DONE.
  - DONE: ResultValidM=1. ResultM and RdM are held stable until ResultValidM&ResultReadyM. On that handshake: go to IDLE, or accept a new request on the same edge if ValidE (ReadyE=ResultReadyM in DONE).
- Latency:
  - Normal ops: accept at edge N, ResultValidM first high after edge N+XLEN+1.
  - Special cases: ResultValidM high after edge N+1.
- Signed handling:
  - MUL/MULH take both operands signed. MULHSU takes A signed, B unsigned. MULHU and DIVU/REMU are unsigned.
  - Negate the result iff the operand signs differ (quotient/product); the remainder takes the sign of the dividend.
  - MUL returns product[XLEN-1:0]; MULH* return product[2XLEN-1:XLEN].
- Special cases (DONE in 1 cycle):
  - Divide by zero: quotient all-ones, remainder = dividend.
  - Signed overflow (min_int / -1): quotient = min_int, remainder = 0.
  - Multiply with either operand 0: result 0.
- FlushE:
  - From any state, go to IDLE on the next edge; ResultValidM=0 and no result is emitted.
  - FlushE concurrent with ValidE: the request is dropped.
  - FlushE takes priority over the DONE handshake.
- Asynchronous reset mid-operation clears outputs immediately, regardless of clk.
- BusyE = (state!=IDLE).

Optional Feature:
EXECUTE_MULDIV_FAST_MUL_EN:
- Defined: MUL/MULH/MULHSU/MULHU use a combinational XLEN×XLEN multiplier and go IDLE→DONE with latency 1. Divide behaviour is unchanged.
- Undefined: all multiplies are iterative (XLEN+1 cycles) and no hardware multiplier is inferred.

Decomposition:
- Package muldiv_pkg holds:
  - muldiv_op_e enum (8 funct3 encodings)
  - muldiv_state_e enum (IDLE, CALC, DONE)
  - helper functions is_signed_a/is_signed_b/is_div
- One natural sub-module: div_step, a combinational single restoring-division step (remainder, quotient shift-in), instantiated once.
- Sign fix and special-case detection stay inline.

Test Plan (all with XLEN=32):
1. MUL A=7, B=0xFFFFFFFD → ResultM=0xFFFFFFEB, ResultValidM rises exactly 33 cycles after the accepting edge, RdM echoes RdE.
2. MULHU A=B=0xFFFFFFFF → 0xFFFFFFFE; MULH same operands → 0x00000000; MULHSU A=0xFFFFFFFF, B=2 → 0xFFFFFFFF.
3. DIV A=0xFFFFFFF9 (−7), B=2 → 0xFFFFFFFD; REM same → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
4. Special cases:
   - DIVU 5/0 → 0xFFFFFFFF after 1 cycle; REM 5/0 → 5.
   - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0, both with 1-cycle latency.
5. Backpressure:
   - Hold ResultReadyM=0 for 5 cycles in DONE → ResultM/RdM stable, ReadyE=0.
   - Then ResultReadyM=1 with ValidE=1 → new request accepted on the same edge, BusyE stays 1.
6. Flush and reset:
   - FlushE at iteration 10 of a DIV → IDLE next edge, no ResultValidM ever.
   - rst_n low mid-CALC → all outputs at reset values without waiting for a clock edge.
